// File: rtl/reg_watch_if.sv
// reg_watch_if: write-back snoop, configuration and event-drain signals of
// reg_watch_unit. The unit takes the slave modport; the driver side
// (datapath glue or a testbench) takes the master modport.
interface reg_watch_if #(
  parameter int NUM_CH = 4,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int TMO_W  = 24
);
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  // register-file write-back snoop
  logic              wb_en;
  logic [ADDR_W-1:0] wb_addr;
  logic [DATA_W-1:0] wb_data;

  // channel configuration
  logic              cfg_valid;
  logic              cfg_ready;
  logic [CH_W-1:0]   cfg_ch;
  logic              cfg_disarm;
  logic [ADDR_W-1:0] cfg_reg;
  logic [DATA_W-1:0] cfg_value;
  logic [DATA_W-1:0] cfg_mask;
  logic [TMO_W-1:0]  cfg_timeout;

  // per-channel status
  logic [NUM_CH-1:0] ch_armed;
  logic [NUM_CH-1:0] ch_hit;
  logic [NUM_CH-1:0] ch_tmo;

  // event drain
  logic              evt_valid;
  logic              evt_ready;
  logic [CH_W-1:0]   evt_ch;
  logic              evt_is_tmo;
  logic [31:0]       evt_cycle;

  modport master (
    output wb_en, wb_addr, wb_data,
    output cfg_valid, cfg_ch, cfg_disarm, cfg_reg, cfg_value, cfg_mask, cfg_timeout,
    input  cfg_ready,
    input  ch_armed, ch_hit, ch_tmo,
    input  evt_valid, evt_ch, evt_is_tmo, evt_cycle,
    output evt_ready
  );

  modport slave (
    input  wb_en, wb_addr, wb_data,
    input  cfg_valid, cfg_ch, cfg_disarm, cfg_reg, cfg_value, cfg_mask, cfg_timeout,
    output cfg_ready,
    output ch_armed, ch_hit, ch_tmo,
    output evt_valid, evt_ch, evt_is_tmo, evt_cycle,
    input  evt_ready
  );
endinterface

// File: rtl/reg_watch_unit.sv
// reg_watch_unit: multi-channel watchpoint on the register-file write-back
// port. Each channel waits for a masked value written to one register, or
// gives up after a cycle budget. Fired channels are kept in a pending bitmap
// and drained lowest index first through a registered valid/ready port.
// Optional: define REG_WATCH_CYCLE_STAMP_EN to add a free-running cycle
// counter whose value is stamped on every HIT/TMO and shown on evt_cycle;
// otherwise evt_cycle is constant 0.
module reg_watch_unit #(
  parameter int NUM_CH = 4,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int TMO_W  = 24
) (
  input logic       clk,
  input logic       rst,
  reg_watch_if.slave bus
);
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_HIT   = 2'd2,
    ST_TMO   = 2'd3
  } ch_state_t;

  ch_state_t         state_r [NUM_CH];
  logic [ADDR_W-1:0] reg_r   [NUM_CH];
  logic [DATA_W-1:0] value_r [NUM_CH];
  logic [DATA_W-1:0] mask_r  [NUM_CH];
  logic [TMO_W-1:0]  cnt_r   [NUM_CH];

  logic [NUM_CH-1:0] armed_r, hit_r, tmo_r, pend_r;
  logic              cfg_ready_r;
  logic              evt_valid_r, evt_is_tmo_r;
  logic [CH_W-1:0]   evt_ch_r;

  logic              cfg_fire_s, evt_fire_s, hold_s, sel_is_tmo_s;
  logic [NUM_CH-1:0] cfg_sel_s, match_s, hit_s, tmo_s, pend_next_s;
  logic [CH_W-1:0]   sel_s;
  logic [31:0]       sel_stamp_s;

`ifdef REG_WATCH_CYCLE_STAMP_EN
  logic [31:0] cyc_r;
  logic [31:0] stamp_r [NUM_CH];
  logic [31:0] evt_cycle_r;
`endif

  // Per-channel decode: config select, masked match, final timeout count, next pending bitmap.
  always_comb begin
    cfg_fire_s  = bus.cfg_valid & cfg_ready_r;
    evt_fire_s  = evt_valid_r & bus.evt_ready;
    cfg_sel_s   = '0;
    match_s     = '0;
    hit_s       = '0;
    tmo_s       = '0;
    pend_next_s = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      cfg_sel_s[c] = cfg_fire_s && (bus.cfg_ch == CH_W'(c));
      // x0 is hard-wired zero, so writes to it are never interesting
      match_s[c]   = (state_r[c] == ST_ARMED) && bus.wb_en &&
                     (bus.wb_addr == reg_r[c]) && (bus.wb_addr != '0) &&
                     (((bus.wb_data ^ value_r[c]) & mask_r[c]) == '0);
      // a config to the same channel overrides whatever it would have fired
      hit_s[c]     = match_s[c] && !cfg_sel_s[c];
      tmo_s[c]     = (state_r[c] == ST_ARMED) && (cnt_r[c] == TMO_W'(1)) &&
                     !match_s[c] && !cfg_sel_s[c];
      if (cfg_sel_s[c]) begin
        pend_next_s[c] = 1'b0;
      end else if (hit_s[c] || tmo_s[c]) begin
        pend_next_s[c] = 1'b1;
      end else if (evt_fire_s && (evt_ch_r == CH_W'(c))) begin
        pend_next_s[c] = 1'b0;
      end else begin
        pend_next_s[c] = pend_r[c];
      end
    end
  end

  // Pick the lowest-index pending channel and decide whether the presented event must be held.
  always_comb begin
    sel_s = '0;
    for (int c = NUM_CH - 1; c >= 0; c--) begin
      if (pend_next_s[c]) begin
        sel_s = CH_W'(c);
      end else begin
        sel_s = sel_s;
      end
    end
    sel_is_tmo_s = tmo_s[sel_s] || (state_r[sel_s] == ST_TMO);
`ifdef REG_WATCH_CYCLE_STAMP_EN
    sel_stamp_s  = (hit_s[sel_s] || tmo_s[sel_s]) ? cyc_r : stamp_r[sel_s];
`else
    sel_stamp_s  = 32'd0;
`endif
    // held only while stalled and the shown entry has not been dropped by a re-arm
    hold_s = evt_valid_r && !bus.evt_ready && pend_next_s[evt_ch_r];
  end

  // Channel state machines, latched configuration, timeout counters, status flags.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int c = 0; c < NUM_CH; c++) begin
        state_r[c] <= ST_IDLE;
        reg_r[c]   <= '0;
        value_r[c] <= '0;
        mask_r[c]  <= '0;
        cnt_r[c]   <= '0;
      end
      armed_r     <= '0;
      hit_r       <= '0;
      tmo_r       <= '0;
      pend_r      <= '0;
      cfg_ready_r <= 1'b0;
    end else begin
      cfg_ready_r <= 1'b1;
      pend_r      <= pend_next_s;
      for (int c = 0; c < NUM_CH; c++) begin
        if (cfg_sel_s[c]) begin
          hit_r[c] <= 1'b0;
          tmo_r[c] <= 1'b0;
          if (bus.cfg_disarm) begin
            state_r[c] <= ST_IDLE;
            armed_r[c] <= 1'b0;
          end else begin
            state_r[c] <= ST_ARMED;
            armed_r[c] <= 1'b1;
            reg_r[c]   <= bus.cfg_reg;
            value_r[c] <= bus.cfg_value;
            mask_r[c]  <= bus.cfg_mask;
            cnt_r[c]   <= bus.cfg_timeout;
          end
        end else if (hit_s[c]) begin
          state_r[c] <= ST_HIT;
          armed_r[c] <= 1'b0;
          hit_r[c]   <= 1'b1;
        end else if (tmo_s[c]) begin
          state_r[c] <= ST_TMO;
          armed_r[c] <= 1'b0;
          tmo_r[c]   <= 1'b1;
        end else if ((state_r[c] == ST_ARMED) && (cnt_r[c] != '0)) begin
          cnt_r[c] <= cnt_r[c] - TMO_W'(1);
        end
      end
    end
  end

  // Registered event presentation: hold while stalled, else show the lowest pending entry.
  always_ff @(posedge clk) begin
    if (!rst) begin
      evt_valid_r  <= 1'b0;
      evt_ch_r     <= '0;
      evt_is_tmo_r <= 1'b0;
    end else if (!hold_s) begin
      evt_valid_r  <= |pend_next_s;
      evt_ch_r     <= sel_s;
      evt_is_tmo_r <= (|pend_next_s) && sel_is_tmo_s;
    end
  end

`ifdef REG_WATCH_CYCLE_STAMP_EN
  // Free-running cycle counter, per-channel stamp capture, presented stamp.
  always_ff @(posedge clk) begin
    if (!rst) begin
      cyc_r       <= 32'd0;
      evt_cycle_r <= 32'd0;
      for (int c = 0; c < NUM_CH; c++) begin
        stamp_r[c] <= 32'd0;
      end
    end else begin
      cyc_r <= cyc_r + 32'd1;
      for (int c = 0; c < NUM_CH; c++) begin
        if (hit_s[c] || tmo_s[c]) begin
          stamp_r[c] <= cyc_r;
        end
      end
      if (!hold_s) begin
        evt_cycle_r <= (|pend_next_s) ? sel_stamp_s : 32'd0;
      end
    end
  end

  assign bus.evt_cycle = evt_cycle_r;
`else
  assign bus.evt_cycle = sel_stamp_s;
`endif

  assign bus.cfg_ready  = cfg_ready_r;
  assign bus.ch_armed   = armed_r;
  assign bus.ch_hit     = hit_r;
  assign bus.ch_tmo     = tmo_r;
  assign bus.evt_valid  = evt_valid_r;
  assign bus.evt_ch     = evt_ch_r;
  assign bus.evt_is_tmo = evt_is_tmo_r;
endmodule

// File: tb/tb_reg_watch_unit.sv
// tb_reg_watch_unit: directed test of reg_watch_unit. Expected events are
// queued when the triggering stimulus is issued; a monitor pops and compares
// on every evt_valid/evt_ready handshake.
module tb_reg_watch_unit;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  reg_watch_if #(.NUM_CH(4), .DATA_W(32), .ADDR_W(5), .TMO_W(24)) bus ();

  reg_watch_unit #(.NUM_CH(4), .DATA_W(32), .ADDR_W(5), .TMO_W(24)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    int          ch;
    bit          tmo;
    logic [31:0] cyc;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        mon_e;
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] cyc_m    = 32'd0;
  logic [31:0] t_a;

  // reference cycle count: zero during reset, +1 per released edge
  always @(posedge clk) begin
    if (!rst) cyc_m <= 32'd0;
    else      cyc_m <= cyc_m + 32'd1;
  end

  function automatic logic [31:0] exp_stamp(input logic [31:0] v);
`ifdef REG_WATCH_CYCLE_STAMP_EN
    return v;
`else
    return v & 32'h0000_0000;
`endif
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg(input int ch, input bit disarm, input logic [4:0] rg,
                     input logic [31:0] val, input logic [31:0] mask, input logic [23:0] tmo);
    bus.cfg_valid   = 1'b1;
    bus.cfg_ch      = 2'(ch);
    bus.cfg_disarm  = disarm;
    bus.cfg_reg     = rg;
    bus.cfg_value   = val;
    bus.cfg_mask    = mask;
    bus.cfg_timeout = tmo;
    step();
    bus.cfg_valid   = 1'b0;
    bus.cfg_disarm  = 1'b0;
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    bus.wb_en   = 1'b1;
    bus.wb_addr = a;
    bus.wb_data = d;
    step();
    bus.wb_en   = 1'b0;
  endtask

  task automatic push(input int ch, input bit tmo, input logic [31:0] cyc);
    exp_t e;
    e.ch  = ch;
    e.tmo = tmo;
    e.cyc = exp_stamp(cyc);
    exp_q.push_back(e);
  endtask

  // accept events until every expected one has been seen, bounded
  task automatic drain();
    step();
    bus.evt_ready = 1'b1;
    for (int i = 0; i < 16 && exp_q.size() != 0; i++) step();
    chk("drain_all_events", 32'(exp_q.size()), 32'd0);
    bus.evt_ready = 1'b0;
  endtask

  // monitor: every handshake consumes one expected event
  always @(negedge clk) begin
    if (rst && bus.evt_valid && bus.evt_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL evt_unexpected: got event ch=%0d tmo=%0d, expected none",
                 bus.evt_ch, bus.evt_is_tmo);
      end else begin
        mon_e = exp_q.pop_front();
        chk("evt_ch", 32'(bus.evt_ch), 32'(mon_e.ch));
        chk("evt_is_tmo", 32'(bus.evt_is_tmo), 32'(mon_e.tmo));
        chk("evt_cycle", bus.evt_cycle, mon_e.cyc);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.wb_en = 1'b0; bus.wb_addr = '0; bus.wb_data = '0;
    bus.cfg_valid = 1'b0; bus.cfg_ch = '0; bus.cfg_disarm = 1'b0;
    bus.cfg_reg = '0; bus.cfg_value = '0; bus.cfg_mask = '0; bus.cfg_timeout = '0;
    bus.evt_ready = 1'b0;

    // reset held for 4 edges
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("rst_cfg_ready", 32'(bus.cfg_ready), 32'd0);
    chk("rst_evt_valid", 32'(bus.evt_valid), 32'd0);
    chk("rst_ch_armed", 32'(bus.ch_armed), 32'd0);
    chk("rst_ch_hit", 32'(bus.ch_hit), 32'd0);
    chk("rst_ch_tmo", 32'(bus.ch_tmo), 32'd0);
    chk("rst_evt_ch", 32'(bus.evt_ch), 32'd0);
    chk("rst_evt_cycle", bus.evt_cycle, 32'd0);
    rst = 1'b1;
    @(negedge clk);
    chk("cfg_ready_after_rst", 32'(bus.cfg_ready), 32'd1);
    chk("evt_valid_after_rst", 32'(bus.evt_valid), 32'd0);

    // basic hit
    cfg(0, 1'b0, 5'd20, 32'd1, 32'hFFFF_FFFF, 24'd0);
    chk("arm_ch0", 32'(bus.ch_armed), 32'h1);
    wr(5'd20, 32'd0);
    @(negedge clk);
    chk("x20_0_no_hit", 32'(bus.ch_hit), 32'h0);
    push(0, 1'b0, cyc_m);
    wr(5'd20, 32'd1);
    @(negedge clk);
    chk("basic_hit", 32'(bus.ch_hit), 32'h1);
    chk("basic_evt_valid", 32'(bus.evt_valid), 32'd1);
    chk("basic_evt_ch", 32'(bus.evt_ch), 32'd0);
    chk("basic_evt_is_tmo", 32'(bus.evt_is_tmo), 32'd0);
    drain();
    @(negedge clk);
    chk("basic_drained", 32'(bus.evt_valid), 32'd0);

    // x0 never matches; masked compare
    cfg(1, 1'b0, 5'd0, 32'd0, 32'd0, 24'd0);
    wr(5'd0, 32'd5);
    @(negedge clk);
    chk("x0_no_hit", 32'(bus.ch_hit), 32'h1);
    chk("x0_still_armed", 32'(bus.ch_armed), 32'h2);
    cfg(2, 1'b0, 5'd11, 32'h1234_5678, 32'h0000_FFFF, 24'd0);
    wr(5'd11, 32'hAAAA_5679);
    @(negedge clk);
    chk("mask_miss", 32'(bus.ch_hit), 32'h1);
    push(2, 1'b0, cyc_m);
    wr(5'd11, 32'hAAAA_5678);
    @(negedge clk);
    chk("mask_hit", 32'(bus.ch_hit), 32'h5);
    drain();

    // timeout of 10 cycles
    t_a = cyc_m;
    push(3, 1'b1, t_a + 32'd10);
    cfg(3, 1'b0, 5'd1, 32'd300, 32'hFFFF_FFFF, 24'd10);
    repeat (10) @(negedge clk);
    chk("tmo_not_yet", 32'(bus.ch_tmo), 32'h0);
    @(negedge clk);
    chk("tmo_at_10", 32'(bus.ch_tmo), 32'h8);
    chk("tmo_evt_is_tmo", 32'(bus.evt_is_tmo), 32'd1);
    chk("tmo_evt_ch", 32'(bus.evt_ch), 32'd3);
    drain();

    // match on the final count wins over timeout
    cfg(3, 1'b0, 5'd1, 32'd300, 32'hFFFF_FFFF, 24'd10);
    chk("rearm_clears_tmo", 32'(bus.ch_tmo), 32'h0);
    repeat (9) step();
    push(3, 1'b0, cyc_m);
    wr(5'd1, 32'd300);
    @(negedge clk);
    chk("last_cycle_hit", 32'(bus.ch_hit[3]), 32'd1);
    chk("last_cycle_no_tmo", 32'(bus.ch_tmo[3]), 32'd0);
    drain();

    // simultaneous hits, backpressure
    cfg(0, 1'b0, 5'd5, 32'd7, 32'hFFFF_FFFF, 24'd0);
    cfg(2, 1'b0, 5'd5, 32'd7, 32'hFFFF_FFFF, 24'd0);
    push(0, 1'b0, cyc_m);
    push(2, 1'b0, cyc_m);
    wr(5'd5, 32'd7);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_evt_valid", 32'(bus.evt_valid), 32'd1);
      chk("bp_evt_ch_stable", 32'(bus.evt_ch), 32'd0);
    end
    drain();
    @(negedge clk);
    chk("bp_drained", 32'(bus.evt_valid), 32'd0);

    // config and match on the same channel in the same cycle
    cfg(0, 1'b0, 5'd6, 32'd1, 32'hFFFF_FFFF, 24'd0);
    bus.wb_en = 1'b1; bus.wb_addr = 5'd6; bus.wb_data = 32'd1;
    cfg(0, 1'b0, 5'd6, 32'd9, 32'hFFFF_FFFF, 24'd0);
    bus.wb_en = 1'b0;
    @(negedge clk);
    chk("coll_armed", 32'(bus.ch_armed[0]), 32'd1);
    chk("coll_no_hit", 32'(bus.ch_hit[0]), 32'd0);
    chk("coll_no_evt", 32'(bus.evt_valid), 32'd0);
    wr(5'd6, 32'd1);
    @(negedge clk);
    chk("old_value_ignored", 32'(bus.ch_hit[0]), 32'd0);
    push(0, 1'b0, cyc_m);
    wr(5'd6, 32'd9);
    @(negedge clk);
    chk("new_value_hit", 32'(bus.ch_hit[0]), 32'd1);
    drain();

    // disarm
    cfg(1, 1'b1, 5'd0, 32'd0, 32'd0, 24'd0);
    chk("disarm", 32'(bus.ch_armed), 32'h0);

    // reset while an event is pending
    cfg(2, 1'b0, 5'd7, 32'd3, 32'hFFFF_FFFF, 24'd0);
    wr(5'd7, 32'd3);
    @(negedge clk);
    chk("pre_reset_evt", 32'(bus.evt_valid), 32'd1);
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_evt_valid", 32'(bus.evt_valid), 32'd0);
    chk("midrst_ch_hit", 32'(bus.ch_hit), 32'h0);
    chk("midrst_cfg_ready", 32'(bus.cfg_ready), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_cfg_ready_back", 32'(bus.cfg_ready), 32'd1);

    // cycle stamp: hit with the counter at 100
    cfg(1, 1'b0, 5'd8, 32'h55, 32'hFFFF_FFFF, 24'd0);
    for (int i = 0; i < 200 && cyc_m < 32'd100; i++) step();
    chk("stamp_setup", cyc_m, 32'd100);
    push(1, 1'b0, cyc_m);
    wr(5'd8, 32'h55);
    @(negedge clk);
    chk("stamp_evt_valid", 32'(bus.evt_valid), 32'd1);
    chk("stamp_value", bus.evt_cycle, exp_stamp(32'd100));
    drain();
    @(negedge clk);
    chk("final_idle", 32'(bus.evt_valid), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/reg_watch_unit.md
Name: reg_watch_unit

Overview:
- Synthesizable multi-channel watchpoint that snoops the CPU register-file write-back port.
- Each channel is armed with a register number, an expected value, a mask and an optional timeout. The channel reports HIT when a masked write matches, or TIMEOUT when the budget expires first.
- Events are queued and drained via a valid/ready port.
- Sits beside Riscv151, fed from the datapath write-back; used for on-FPGA self-checking of assembly tests.

Parameters:
- NUM_CH, 4, number of independent watch channels (1..16)
- DATA_W, 32, register data width
- ADDR_W, 5, register index width
- TMO_W, 24, timeout counter width

Ports:
- clk  in  1  CPU clock
- rst  in  1  synchronous reset, active-low; all state resets on a rising clk edge while rst==0
- wb_en  in  1  register-file write strobe
- wb_addr  in  ADDR_W  register being written
- wb_data  in  DATA_W  write data
- cfg_valid  in  1  configure/arm request
- cfg_ready  out  1  configuration accepted
- cfg_ch  in  $clog2(NUM_CH) (min 1)  target channel
- cfg_disarm  in  1  1 = return channel to IDLE instead of arming
- cfg_reg  in  ADDR_W  watched register
- cfg_value  in  DATA_W  expected value
- cfg_mask  in  DATA_W  compare mask
- cfg_timeout  in  TMO_W  cycle budget; 0 = no timeout
- ch_armed  out  NUM_CH  channel in ARMED
- ch_hit  out  NUM_CH  sticky HIT flag
- ch_tmo  out  NUM_CH  sticky TIMEOUT flag
- evt_valid  out  1  event pending
- evt_ready  in  1  consumer accepts event
- evt_ch  out  $clog2(NUM_CH) (min 1)  channel of presented event
- evt_is_tmo  out  1  0 = hit, 1 = timeout
- evt_cycle  out  32  cycle stamp of event (see Optional Feature)

Behaviour:
- Reset (rst==0 at edge): all channels IDLE; ch_armed/ch_hit/ch_tmo = 0; pending bitmap = 0; evt_valid = 0; evt_ch = 0; evt_is_tmo = 0; evt_cycle = 0; cfg_ready = 0. cfg_ready = 1 from the first edge after rst deasserts.
- Reset mid-operation discards all armed channels and pending events.
- Per-channel FSM: IDLE, ARMED, HIT, TMO.
- Configuration: a handshake (cfg_valid & cfg_ready) on channel c takes effect at that edge.
  - cfg_disarm=1 moves c to IDLE.
  - Otherwise c latches reg/value/mask/timeout and moves to ARMED from any state.
  - Any arm or disarm clears c's sticky flags and its pending bit.
- Match in ARMED: requires wb_en=1, wb_addr==cfg_reg, wb_addr!=0, and (wb_data & mask)==(value & mask). Writes to x0 never match.
  - On a match, the FSM moves to HIT at the same edge, ch_hit[c] sets, and the pending bit sets. Flags are visible 1 cycle after the write-back cycle.
- Timeout: while ARMED with timeout!=0, the remaining counter loads timeout at arm and decrements every cycle.
  - When the counter is 1 and no match occurs this cycle, the FSM moves to TMO and ch_tmo[c] and pending set. A channel armed with timeout=N times out exactly N cycles after arming.
  - Match and final-count in the same cycle: HIT wins.
- HIT/TMO are sticky until re-arm, disarm or reset. Later matching writes are ignored.
- Config to c in the same cycle as a match on c: config wins, the match is discarded.
- Event queue: a pending bitmap holds one entry per channel; evt_* presents the lowest-index pending channel, registered.
  - evt_valid & evt_ready clears that bit at the edge; the next pending entry is presented the following cycle.
  - Several channels firing in the same cycle all set pending and drain in index order.
  - While evt_valid=1 and evt_ready=0, evt_ch/evt_is_tmo/evt_cycle are held stable unless that channel is re-armed. A re-arm drops that entry and the lowest remaining entry is presented the next cycle.

Optional Feature:
- Macro: REG_WATCH_CYCLE_STAMP_EN
- Defined:
  - A 32-bit free-running cycle counter, cleared by reset and wrapping at 2^32, increments every cycle.
  - Each channel captures the counter value at its HIT/TMO edge into a per-channel stamp register.
  - evt_cycle presents the stamp of the presented channel.
- Undefined: no counter or stamp registers; evt_cycle is tied to 0.

Test Plan:
- Reset: hold rst=0 for 4 cycles, release -> all outputs 0 during reset, cfg_ready=1 the next cycle, evt_valid=0.
- Basic hit: arm ch0 reg=20, value=1, mask=FFFFFFFF, timeout=0; write x20=0 then x20=1 -> ch_hit[0]=1 one cycle after the second write; evt_valid=1, evt_ch=0, evt_is_tmo=0; evt_ready=1 clears evt_valid.
- Mask and x0: arm ch1 reg=0, value=0, mask=0; write x0=5 -> no hit. Arm ch2 reg=11, value=12345678, mask=0000FFFF; write x11=AAAA5678 -> ch_hit[2]=1.
- Timeout: arm ch3 reg=1, value=300, timeout=10, no writes -> ch_tmo[3]=1 exactly 10 cycles after arming, evt_is_tmo=1. Write x1=300 on cycle 10 -> HIT instead of TMO.
- Simultaneous events with backpressure: arm ch0 and ch2 on reg=5, value=7; write x5=7; hold evt_ready=0 for 5 cycles -> evt_ch=0 stable; then evt_ready=1 -> ch0, then ch2 next cycle, then evt_valid=0.
- Re-arm collision and cycle stamp: arm ch0 on reg=6 and issue cfg (value=9) in the same cycle x6 matches the old value -> no hit, ch_armed[0]=1. With REG_WATCH_CYCLE_STAMP_EN, a hit at counter 100 yields evt_cycle=100; without the macro, evt_cycle=0.
